// File: rtl/tx_bram_loader_pkg.sv
// Shared state encoding and helpers for the tx BRAM loader.
package tx_bram_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        START,
        WAIT_STARTED,
        WAIT_DONE
    } state_e;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEPTH = 1 << DEF_ADDR_WIDTH;

    function automatic int tmo_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/tx_start_watchdog.sv
// Counts cycles spent waiting for phy_tx_started; flags when the limit is hit.
module tx_start_watchdog #(
    parameter int START_TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);
    import tx_bram_loader_pkg::*;

    localparam int CW = tmo_width(START_TIMEOUT);
    localparam logic [CW-1:0] LIMIT = CW'(START_TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en && cnt_q != LIMIT) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // Fires in the cycle whose edge brings the count to the limit.
    assign expired = en && !clear && (cnt_d == LIMIT);

endmodule

// File: rtl/tx_bram_loader.sv
// Writes one packet stream into the tx BRAM, then starts and tracks the PHY.
// Optional TX_BRAM_LOADER_LEN_EN adds last_len/len_valid outputs.
module tx_bram_loader #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDR_WIDTH    = 10,
    parameter int START_TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_dout,
    output logic                  phy_tx_start,
    input  logic                  phy_tx_started,
    input  logic                  phy_tx_done,
    output logic                  busy,
    output logic                  overflow,
    output logic                  timeout_err,
`ifdef TX_BRAM_LOADER_LEN_EN
    output logic [ADDR_WIDTH:0]   last_len,
    output logic                  len_valid,
`endif
    input  logic                  clr_err
);
    import tx_bram_loader_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    tready_q, tready_d;
    logic                    bram_we_q, bram_we_d;
    logic [ADDR_WIDTH-1:0]   bram_addr_q, bram_addr_d;
    logic [DATA_WIDTH-1:0]   bram_dout_q, bram_dout_d;
    logic                    start_q, start_d;
    logic                    busy_q, busy_d;
    logic                    overflow_q, overflow_d;
    logic                    timeout_err_q, timeout_err_d;
    logic                    hs, wd_clear, wd_en, wd_expired;

    assign hs = s_axis_tvalid & tready_q;

    tx_start_watchdog #(
        .START_TIMEOUT(START_TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .en     (wd_en),
        .expired(wd_expired)
    );

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        bram_we_d     = 1'b0;
        bram_addr_d   = bram_addr_q;
        bram_dout_d   = bram_dout_q;
        start_d       = 1'b0;
        overflow_d    = overflow_q;
        timeout_err_d = timeout_err_q;
        wd_clear      = 1'b0;
        wd_en         = 1'b0;
        if (clr_err) begin
            overflow_d    = 1'b0;
            timeout_err_d = 1'b0;
        end
        unique case (state_q)
            IDLE, LOAD: begin
                if (hs) begin
                    bram_we_d   = 1'b1;
                    bram_addr_d = addr_q;
                    bram_dout_d = s_axis_tdata;
                    if (s_axis_tlast) begin
                        state_d = START;
                    end else if (addr_q == LAST_ADDR) begin
                        overflow_d = 1'b1;
                        state_d    = DRAIN;
                    end else begin
                        state_d = LOAD;
                    end
                    if (addr_q != LAST_ADDR) addr_d = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                if (hs && s_axis_tlast) state_d = START;
            end
            START: begin
                start_d  = 1'b1;
                wd_clear = 1'b1;
                state_d  = WAIT_STARTED;
            end
            WAIT_STARTED: begin
                wd_en = 1'b1;
                if (phy_tx_started) begin
                    state_d = phy_tx_done ? IDLE : WAIT_DONE;
                end else if (wd_expired) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            WAIT_DONE: begin
                if (phy_tx_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Every packet, finished or timed out, restarts at word 0.
        if (state_d == IDLE) addr_d = '0;
        tready_d = (state_d == IDLE) || (state_d == LOAD) ||
                   (state_d == DRAIN);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            tready_q      <= 1'b0;
            bram_we_q     <= 1'b0;
            bram_addr_q   <= '0;
            bram_dout_q   <= '0;
            start_q       <= 1'b0;
            busy_q        <= 1'b0;
            overflow_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            tready_q      <= tready_d;
            bram_we_q     <= bram_we_d;
            bram_addr_q   <= bram_addr_d;
            bram_dout_q   <= bram_dout_d;
            start_q       <= start_d;
            busy_q        <= busy_d;
            overflow_q    <= overflow_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign bram_we       = bram_we_q;
    assign bram_addr     = bram_addr_q;
    assign bram_dout     = bram_dout_q;
    assign phy_tx_start  = start_q;
    assign busy          = busy_q;
    assign overflow      = overflow_q;
    assign timeout_err   = timeout_err_q;

`ifdef TX_BRAM_LOADER_LEN_EN
    logic [ADDR_WIDTH:0] wr_cnt_q, wr_cnt_d;
    logic [ADDR_WIDTH:0] last_len_q, last_len_d;
    logic                len_valid_q;

    always_comb begin
        wr_cnt_d   = wr_cnt_q;
        last_len_d = last_len_q;
        if (bram_we_d) wr_cnt_d = wr_cnt_q + 1'b1;
        if (state_q == START) last_len_d = wr_cnt_q;
        if (state_d == IDLE) wr_cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q    <= '0;
            last_len_q  <= '0;
            len_valid_q <= 1'b0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            last_len_q  <= last_len_d;
            len_valid_q <= start_d;
        end
    end

    assign last_len  = last_len_q;
    assign len_valid = len_valid_q;
`endif

endmodule

// File: tb/tb_tx_bram_loader.sv
// Directed/randomised bench for tx_bram_loader against a packet-level model.
module tb_tx_bram_loader;

    localparam int DW    = 64;
    localparam int AW    = 10;
    localparam int T     = 1023;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_dout;
    logic          phy_tx_start;
    logic          phy_tx_started = 1'b0;
    logic          phy_tx_done = 1'b0;
    logic          busy;
    logic          overflow;
    logic          timeout_err;
    logic          clr_err = 1'b0;
`ifdef TX_BRAM_LOADER_LEN_EN
    logic [AW:0]   last_len;
    logic          len_valid;
`endif

    tx_bram_loader #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .START_TIMEOUT(T)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .bram_we       (bram_we),
        .bram_addr     (bram_addr),
        .bram_dout     (bram_dout),
        .phy_tx_start  (phy_tx_start),
        .phy_tx_started(phy_tx_started),
        .phy_tx_done   (phy_tx_done),
        .busy          (busy),
        .overflow      (overflow),
        .timeout_err   (timeout_err),
`ifdef TX_BRAM_LOADER_LEN_EN
        .last_len      (last_len),
        .len_valid     (len_valid),
`endif
        .clr_err       (clr_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            errors = 0;
    int            checks = 0;
    int            wr_addr[$];
    logic [DW-1:0] wr_data[$];
    int            wr_cyc[$];
    int            st_cyc[$];
    logic [DW-1:0] sent[$];
    int            hs_cyc[$];

    always @(negedge clk) begin
        if (bram_we) begin
            wr_addr.push_back(int'(bram_addr));
            wr_data.push_back(bram_dout);
            wr_cyc.push_back(cyc);
        end
        if (phy_tx_start) st_cyc.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: tvalid always high, 1: every other cycle, 2: random gaps
    task automatic send_pkt(input string tag, input int n, input int mode,
                            input bit fixed, input bit last_en);
        int i, guard, tick;
        logic [DW-1:0] w;
        logic [7:0] b;
        bit v;
        i = 0; guard = 0; tick = 0;
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        st_cyc.delete(); sent.delete(); hs_cyc.delete();
        b = 8'(8'h11 * 1);
        w = fixed ? {8{b}} : {$urandom, $urandom};
        while (i < n && guard < 4 * n + 50) begin
            @(negedge clk);
            if (mode == 1)      v = (tick % 2) == 0;
            else if (mode == 2) v = $urandom_range(0, 2) != 0;
            else                v = 1'b1;
            tick++;
            guard++;
            s_axis_tvalid = v;
            s_axis_tdata  = w;
            s_axis_tlast  = last_en && (i == n - 1);
            if (v && s_axis_tready) begin
                sent.push_back(w);
                hs_cyc.push_back(cyc);
                i++;
                b = 8'(8'h11 * (i + 1));
                w = fixed ? {8{b}} : {$urandom, $urandom};
            end
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        chk({tag, "_accepted"}, 64'(i), 64'(n));
    endtask

    task automatic check_pkt(input string tag, input int n);
        int nw, bad, last;
        nw  = (n > DEPTH) ? DEPTH : n;
        bad = 0;
        chk({tag, "_nwr"}, 64'(wr_addr.size()), 64'(nw));
        for (int k = 0; k < nw && k < wr_addr.size(); k++) begin
            if (wr_addr[k] != k || wr_data[k] !== sent[k] ||
                wr_cyc[k] != hs_cyc[k] + 1)
                bad++;
        end
        chk({tag, "_wrbad"}, 64'(bad), 64'(0));
        chk({tag, "_nstart"}, 64'(st_cyc.size()), 64'(1));
        last = (hs_cyc.size() > 0) ? hs_cyc[hs_cyc.size() - 1] : -100;
        chk({tag, "_tstart"}, 64'((st_cyc.size() > 0) ? st_cyc[0] : -1),
            64'(last + 2));
        chk({tag, "_ovf"}, 64'(overflow), 64'(n > DEPTH));
    endtask

    task automatic finish_tx(input string tag, input bit together);
        repeat (3) @(negedge clk);
        phy_tx_started = 1'b1;
        phy_tx_done    = together;
        @(negedge clk);
        phy_tx_started = 1'b0;
        phy_tx_done    = 1'b0;
        if (!together) begin
            repeat (4) @(negedge clk);
            chk({tag, "_busy_wait"}, 64'(busy), 64'(1));
            phy_tx_done = 1'b1;
            @(negedge clk);
            phy_tx_done = 1'b0;
        end
        chk({tag, "_busy_end"}, 64'(busy), 64'(0));
        chk({tag, "_tready_end"}, 64'(s_axis_tready), 64'(1));
    endtask

    initial begin : main
        int t0;
        int n;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ctl", 64'({s_axis_tready, bram_we, bram_addr, phy_tx_start,
                              busy, overflow, timeout_err}), 64'(0));
        chk("reset_data", bram_dout, 64'(0));
        rst = 1'b0;

        send_pkt("p3", 3, 0, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check_pkt("p3", 3);
        chk("p3_busy", 64'(busy), 64'(1));
        finish_tx("p3", 1'b0);

        send_pkt("p1", 1, 0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check_pkt("p1", 1);
        finish_tx("p1", 1'b0);

        send_pkt("tog", 8, 1, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check_pkt("tog", 8);
        finish_tx("tog", 1'b0);

        n = $urandom_range(10, 40);
        send_pkt("rnd", n, 2, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check_pkt("rnd", n);
        finish_tx("rnd", 1'b1);

        send_pkt("ovf", DEPTH + 6, 0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check_pkt("ovf", DEPTH + 6);
        finish_tx("ovf", 1'b0);
        chk("ovf_sticky", 64'(overflow), 64'(1));
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("ovf_clr", 64'(overflow), 64'(0));

        send_pkt("tmo", 2, 0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check_pkt("tmo", 2);
        t0 = -1;
        for (int k = 0; k < T + 50 && t0 < 0; k++) begin
            @(negedge clk);
            if (timeout_err) t0 = cyc;
        end
        chk("tmo_time", 64'(t0),
            64'((st_cyc.size() > 0) ? st_cyc[0] + T : -2));
        chk("tmo_idle", 64'(busy), 64'(0));
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("tmo_clr", 64'(timeout_err), 64'(0));

        send_pkt("mid", 5, 0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ctl", 64'({s_axis_tready, bram_we, bram_addr,
                                phy_tx_start, busy, overflow, timeout_err}),
            64'(0));
        chk("mid_rst_data", bram_dout, 64'(0));
        rst = 1'b0;
        st_cyc.delete();
        repeat (5) @(negedge clk);
        chk("mid_nostart", 64'(st_cyc.size()), 64'(0));
        chk("mid_idle", 64'(busy), 64'(0));

        send_pkt("post", 3, 2, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check_pkt("post", 3);
        finish_tx("post", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1, "bench time budget exceeded");
    end

endmodule
